// File: rtl/mmio_bus.sv
// MMIO decoder between the load/store unit and RAM, keyboard FIFO, switches, SEG/LED and RTC.
// Latency: response registered one cycle after acceptance; RAM read data muxed in that cycle.
// Backpressure: req_ready is tied high; the keyboard source is throttled by kb_ready (FIFO not full).
module mmio_bus #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 64,
    parameter int          KB_W     = 16,
    parameter int          KB_DEPTH = 8,
    parameter int          SEG_W    = 32,
    parameter int          LED_W    = 16,
    parameter logic [31:0] RAM_BASE = 32'h8000_0000,
    parameter logic [31:0] RAM_LEN  = 32'h0800_0000,
    parameter logic [31:0] KBD_ADDR = 32'ha000_0060,
    parameter logic [31:0] SWT_ADDR = 32'ha000_0080,
    parameter logic [31:0] SEG_ADDR = 32'ha000_0090,
    parameter logic [31:0] LED_ADDR = 32'ha000_00a0,
    parameter logic [31:0] RTC_ADDR = 32'ha000_0048,
    parameter int          PERI_LEN = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wstrb,
    input  logic [DATA_W-1:0]   ram_rdata,
    input  logic                kb_valid,
    input  logic [KB_W-1:0]     kb_data,
    output logic                kb_ready,
    input  logic [7:0]          swt_in,
    input  logic [63:0]         rtc_cnt,
    output logic [SEG_W-1:0]    seg_out,
    output logic [LED_W-1:0]    led_out,
    output logic                err_valid,
    output logic [ADDR_W-1:0]   err_addr
);
    localparam int PTR_W = $clog2(KB_DEPTH);
    localparam int CNT_W = $clog2(KB_DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(KB_DEPTH);
    localparam logic [ADDR_W-1:0] RAM_A  = ADDR_W'(RAM_BASE);
    localparam logic [ADDR_W-1:0] RAM_L  = ADDR_W'(RAM_LEN);
    localparam logic [ADDR_W-1:0] KBD_A  = ADDR_W'(KBD_ADDR);
    localparam logic [ADDR_W-1:0] SWT_A  = ADDR_W'(SWT_ADDR);
    localparam logic [ADDR_W-1:0] SEG_A  = ADDR_W'(SEG_ADDR);
    localparam logic [ADDR_W-1:0] LED_A  = ADDR_W'(LED_ADDR);
    localparam logic [ADDR_W-1:0] RTC_A  = ADDR_W'(RTC_ADDR);
    localparam logic [ADDR_W-1:0] PERI_L = ADDR_W'(PERI_LEN);

    function automatic logic in_win(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] len);
        return (a >= base) && ((a - base) < len);
    endfunction

    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_ram_q, rsp_ram_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic                err_valid_q, err_valid_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [31:0]         rtc_shadow_q, rtc_shadow_d;
    logic [KB_W-1:0]     kb_mem_q [KB_DEPTH];
    logic [KB_W-1:0]     kb_mem_d [KB_DEPTH];
    logic [PTR_W-1:0]    kb_wr_ptr_q, kb_wr_ptr_d, kb_rd_ptr_q, kb_rd_ptr_d;
    logic [CNT_W-1:0]    kb_cnt_q, kb_cnt_d;
    logic                kb_ovf_q, kb_ovf_d;

    logic ram_hit, kbd_hit, swt_hit, seg_hit, led_hit, rtc_hit;
    logic kb_push, kb_pop, kb_full, ovf_clr;
    logic [ADDR_W-1:0] kbd_off, rtc_off;

    assign kbd_off = req_addr - KBD_A;
    assign rtc_off = req_addr - RTC_A;

    // Priority decode: the earliest window in the chain claims an overlapping address.
    always_comb begin
        ram_hit = in_win(req_addr, RAM_A, RAM_L);
        kbd_hit = !ram_hit && in_win(req_addr, KBD_A, PERI_L);
        swt_hit = !ram_hit && !kbd_hit && in_win(req_addr, SWT_A, PERI_L);
        seg_hit = !ram_hit && !kbd_hit && !swt_hit && in_win(req_addr, SEG_A, PERI_L);
        led_hit = !ram_hit && !kbd_hit && !swt_hit && !seg_hit && in_win(req_addr, LED_A, PERI_L);
        rtc_hit = !ram_hit && !kbd_hit && !swt_hit && !seg_hit && !led_hit
                  && in_win(req_addr, RTC_A, PERI_L);
    end

    assign req_ready = 1'b1;
    assign ram_en    = req_valid && ram_hit;
    assign ram_we    = ram_en && req_we;
    assign ram_addr  = req_addr - RAM_A;
    assign ram_wdata = req_wdata;
    assign ram_wstrb = req_wstrb;
    assign kb_full   = (kb_cnt_q == FULL_CNT);
    assign kb_ready  = !kb_full;
    assign kb_push   = kb_valid && !kb_full;

    always_comb begin
        rsp_valid_d  = req_valid;
        rsp_err_d    = 1'b0;
        rsp_ram_d    = 1'b0;
        rsp_rdata_d  = '0;
        seg_d        = seg_q;
        led_d        = led_q;
        err_valid_d  = err_valid_q;
        err_addr_d   = err_addr_q;
        rtc_shadow_d = rtc_shadow_q;
        kb_pop       = 1'b0;
        ovf_clr      = 1'b0;
        if (req_valid) begin
            if (ram_hit) begin
                rsp_ram_d = !req_we;
            end else if (kbd_hit) begin
                if (req_we) begin
                    rsp_err_d = 1'b1;
                end else if (kbd_off == '0) begin
                    // Empty pop returns 0; a same-cycle push is never bypassed.
                    if (kb_cnt_q != '0) begin
                        rsp_rdata_d[KB_W-1:0] = kb_mem_q[kb_rd_ptr_q];
                        kb_pop = 1'b1;
                    end
                end else if (kbd_off == ADDR_W'(8)) begin
                    rsp_rdata_d[DATA_W-1]  = kb_ovf_q;
                    rsp_rdata_d[CNT_W-1:0] = kb_cnt_q;
                    ovf_clr = 1'b1;
                end
            end else if (swt_hit) begin
                if (req_we) rsp_err_d = 1'b1;
                else        rsp_rdata_d[7:0] = swt_in;
            end else if (seg_hit) begin
                if (req_we) begin
                    for (int i = 0; i < SEG_W / 8; i++)
                        if (req_wstrb[i]) seg_d[i*8 +: 8] = req_wdata[i*8 +: 8];
                end else begin
                    rsp_rdata_d[SEG_W-1:0] = seg_q;
                end
            end else if (led_hit) begin
                if (req_we) begin
                    for (int i = 0; i < LED_W / 8; i++)
                        if (req_wstrb[i]) led_d[i*8 +: 8] = req_wdata[i*8 +: 8];
                end else begin
                    rsp_rdata_d[LED_W-1:0] = led_q;
                end
            end else if (rtc_hit) begin
                if (req_we) begin
                    rsp_err_d = 1'b1;
                end else if (rtc_off == '0) begin
                    // Latch the high half now so a later +4 read pairs with this low half.
                    rsp_rdata_d[31:0] = rtc_cnt[31:0];
                    rtc_shadow_d      = rtc_cnt[63:32];
                end else if (rtc_off == ADDR_W'(4)) begin
                    rsp_rdata_d[31:0] = rtc_shadow_q;
                end
            end else begin
                rsp_err_d = 1'b1;
            end
            if (rsp_err_d && !err_valid_q) begin
                err_valid_d = 1'b1;
                err_addr_d  = req_addr;
            end
        end
    end

    always_comb begin
        kb_mem_d    = kb_mem_q;
        kb_wr_ptr_d = kb_wr_ptr_q;
        kb_rd_ptr_d = kb_rd_ptr_q;
        kb_cnt_d    = kb_cnt_q;
        kb_ovf_d    = kb_ovf_q;
        if (kb_push) begin
            kb_mem_d[kb_wr_ptr_q] = kb_data;
            kb_wr_ptr_d = kb_wr_ptr_q + 1'b1;
        end
        if (kb_pop) kb_rd_ptr_d = kb_rd_ptr_q + 1'b1;
        case ({kb_push, kb_pop})
            2'b10:   kb_cnt_d = kb_cnt_q + 1'b1;
            2'b01:   kb_cnt_d = kb_cnt_q - 1'b1;
            default: kb_cnt_d = kb_cnt_q;
        endcase
        // A fresh overflow in the same cycle as a status read wins over the clear.
        if (ovf_clr) kb_ovf_d = 1'b0;
        if (kb_valid && kb_full) kb_ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_ram_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            seg_q        <= '0;
            led_q        <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            rtc_shadow_q <= '0;
            kb_mem_q     <= '{default: '0};
            kb_wr_ptr_q  <= '0;
            kb_rd_ptr_q  <= '0;
            kb_cnt_q     <= '0;
            kb_ovf_q     <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_ram_q    <= rsp_ram_d;
            rsp_rdata_q  <= rsp_rdata_d;
            seg_q        <= seg_d;
            led_q        <= led_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
            rtc_shadow_q <= rtc_shadow_d;
            kb_mem_q     <= kb_mem_d;
            kb_wr_ptr_q  <= kb_wr_ptr_d;
            kb_rd_ptr_q  <= kb_rd_ptr_d;
            kb_cnt_q     <= kb_cnt_d;
            kb_ovf_q     <= kb_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_ram_q ? ram_rdata : rsp_rdata_q;
    assign seg_out   = seg_q;
    assign led_out   = led_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
endmodule
